ysyx_24080014_axil_sram: RTL and testbench
==========================================

Name: ysyx_24080014_axil_sram

Overview:
AXI4-Lite responder (slave) memory model that services the instruction fetch unit's read requests, and the data side's reads and writes.
- Implements the full AR/R and AW/W/B channel handshakes.
- Programmable response latency, with an optional LFSR-based random delay to stress initiator stall handling.
- Sits at the far end of the fetch/LSU bus, directly behind the initiator ports.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; wstrb is 4 bits)
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words
BASE, 32'h8000_0000, byte address of word 0
RD_LAT, 1, cycles from AR handshake edge to rvalid high (>=1)
WR_LAT, 1, cycles from AW+W complete edge to bvalid high (>=1)
RAND_LAT, 0, 1 = add lfsr[1:0] extra cycles to each latency

Ports:
aclk     in   1   clock, rising edge
aresetn  in   1   asynchronous active-low reset
araddr   in   32  read address
arvalid  in   1   read address valid
arready  out  1   read address ready
rdata    out  32  read data
rresp    out  2   00 OKAY, 10 SLVERR
rvalid   out  1   read data valid
rready   in   1   initiator ready for read data
awaddr   in   32  write address
awvalid  in   1   write address valid
awready  out  1   write address ready
wdata    in   32  write data
wstrb    in   4   byte enables
wvalid   in   1   write data valid
wready   out  1   write data ready
bresp    out  2   00 OKAY, 10 SLVERR
bvalid   out  1   write response valid
bready   in   1   initiator ready for response

Behaviour:
- Reset: aresetn low forces, asynchronously:
  - read and write FSMs to IDLE;
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, all latency counters=0, LFSR=8'hA5.
  - arready, awready, wready read 0 while aresetn is low.
  - Memory contents are NOT reset.
- Address decode:
  - off = addr - BASE; in-range iff off < 4*2^DEPTH_LOG2.
  - Index = off[DEPTH_LOG2+1:2]; addr[1:0] ignored.
- Read FSM:
  - IDLE: arready=1. On arvalid&arready, latch araddr, load cnt = RD_LAT-1 (+lfsr[1:0] if RAND_LAT), go WAIT.
  - WAIT: arready=0. Decrement cnt; when cnt==0, capture rdata/rresp and go RESP.
  - RESP: rvalid=1. rdata and rresp stay stable until rready. On rvalid&rready, go IDLE with rvalid=0.
  - One transaction outstanding; the next AR is accepted no earlier than the cycle after the R handshake.
  - Out of range: rdata=0, rresp=10.
- Write FSM:
  - IDLE: awready=1 and wready=1 independently. AW and W may arrive in the same cycle or in either order.
  - Each channel's ready drops after its own handshake, and its address or data/strb is latched.
  - When both are held, load cnt = WR_LAT-1 (+lfsr), go WAIT.
  - WAIT: count down to 0. On the exiting edge, commit bytes with wstrb[i]=1 (in range only), set bresp, go RESP.
  - RESP: bvalid=1 until bvalid&bready, then IDLE with both readys back to 1.
  - Out of range: no memory change, bresp=10.
- Read/write collision:
  - A write commit and a read capture on the same edge to the same word: the read returns the old data.
  - Write data is visible to any capture on a later edge.
- LFSR:
  - 8-bit, x^8+x^6+x^5+x^4+1, advances every cycle after reset.
  - Used only when RAND_LAT=1.
- Initiator drops valid before handshake: the slave simply waits; no protocol checking.

Test Plan:
1. RD_LAT=WR_LAT=1. AW 0x8000_0010 and W 0xDEADBEEF/4'hF in the same cycle, bready=1 -> bvalid one cycle later, bresp=00. Then AR 0x8000_0010, rready=1 -> rvalid one cycle after AR handshake, rdata=0xDEADBEEF, rresp=00.
2. Write 0x0000_5500 with wstrb=4'b0010 to 0x8000_0010, then read it -> rdata=0xDEAD55EF.
3. Read with rready held low 5 cycles -> rvalid and rdata constant for all 5 cycles, arready=0. An arvalid held high is accepted the cycle after the R handshake.
4. AR 0x0000_0000 -> rresp=10, rdata=0. Write to 0x9000_0000 -> bresp=10; a read of 0x8000_0010 still returns 0xDEAD55EF.
5. AW 0x8000_0020 three cycles before W 0x1234_5678 -> awready=0 after AW while wready stays 1. bvalid rises WR_LAT cycles after the W handshake; readback returns 0x1234_5678.
6. aresetn pulled low while rvalid=1 -> rvalid=0 immediately, without a clock edge. After release, arready=1 and 0x8000_0010 still reads 0xDEAD55EF. With RAND_LAT=1, 20 reads -> every latency lies in 1..4 cycles with correct data.

Source files
------------

// File: rtl/ysyx_24080014_axil_sram.sv
// rtl/ysyx_24080014_axil_sram.sv - AXI4-Lite responder SRAM with programmable and optional random latency
module ysyx_24080014_axil_sram #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
  parameter int                RD_LAT     = 1,
  parameter int                WR_LAT     = 1,
  parameter bit                RAND_LAT   = 1'b0
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int                DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W-1:0] SPAN        = ADDR_W'(DEPTH) << 2;
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [7:0] lfsr_q;
  logic [7:0] extra_lat;

  rd_state_e         rd_state_q, rd_state_d;
  logic [7:0]        rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  wr_state_e         wr_state_q, wr_state_d;
  logic [7:0]        wr_cnt_q, wr_cnt_d;
  logic              aw_got_q, aw_got_d;
  logic              w_got_q, w_got_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              wr_commit;

  logic [ADDR_W-1:0]     rd_off, wr_off;
  logic                  rd_hit, wr_hit;
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
  logic                  ar_hs, aw_hs, w_hs;

  // Address decode: offset from BASE, bounds check, word index (byte lane bits ignored)
  assign rd_off = ar_addr_q - BASE;
  assign wr_off = aw_addr_q - BASE;
  assign rd_hit = rd_off < SPAN;
  assign wr_hit = wr_off < SPAN;
  assign rd_idx = rd_off[DEPTH_LOG2+1:2];
  assign wr_idx = wr_off[DEPTH_LOG2+1:2];

  assign extra_lat = RAND_LAT ? {6'b0, lfsr_q[1:0]} : 8'd0;

  // Readys are gated by reset so an initiator never sees a handshake during reset
  assign arready = aresetn && (rd_state_q == R_IDLE);
  assign awready = aresetn && (wr_state_q == W_IDLE) && !aw_got_q;
  assign wready  = aresetn && (wr_state_q == W_IDLE) && !w_got_q;
  assign ar_hs   = arvalid && arready;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  assign rvalid = (rd_state_q == R_RESP);
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign bvalid = (wr_state_q == W_RESP);
  assign bresp  = bresp_q;

  // Free-running LFSR x^8+x^6+x^5+x^4+1 supplying random extra latency
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Read channel state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= 8'd0;
      ar_addr_q  <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      ar_addr_q  <= ar_addr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Read FSM: accept AR, count latency, capture the word (pre-commit value on a same-edge write), hold until rready
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    ar_addr_d  = ar_addr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          ar_addr_d  = araddr;
          rd_cnt_d   = 8'(RD_LAT - 1) + extra_lat;
          rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_cnt_q == 8'd0) begin
          if (rd_hit) begin
            rdata_d = mem[rd_idx];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
          rd_state_d = R_RESP;
        end else begin
          rd_cnt_d = rd_cnt_q - 8'd1;
        end
      end
      R_RESP: begin
        if (rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write channel state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      wr_cnt_q   <= 8'd0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_addr_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 4'd0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      aw_addr_q  <= aw_addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

  // Write FSM: collect AW and W in any order, count latency, commit on the exiting edge, hold B until bready
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    aw_addr_d  = aw_addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d  = 1'b1;
          aw_addr_d = awaddr;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          wr_cnt_d   = 8'(WR_LAT - 1) + extra_lat;
          wr_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wr_cnt_q == 8'd0) begin
          wr_commit  = 1'b1;
          bresp_d    = wr_hit ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = W_RESP;
        end else begin
          wr_cnt_d = wr_cnt_q - 8'd1;
        end
      end
      W_RESP: begin
        if (bready) begin
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Byte-masked memory commit; storage is deliberately not reset
  always_ff @(posedge aclk) begin
    if (wr_commit && wr_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_axil_sram.sv
// tb/tb_ysyx_24080014_axil_sram.sv - scoreboard bench for the AXI4-Lite SRAM responder
module tb_ysyx_24080014_axil_sram;

  typedef struct {
    int          s;
    logic [31:0] data;
    logic [1:0]  resp;
    int          hs;
    int          lmin;
    int          lmax;
  } exp_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] araddr [2];
  logic [31:0] rdata [2];
  logic [31:0] awaddr [2];
  logic [31:0] wdata [2];
  logic [1:0]  rresp [2];
  logic [1:0]  bresp [2];
  logic [3:0]  wstrb [2];
  logic        arvalid [2];
  logic        arready [2];
  logic        rvalid [2];
  logic        rready [2];
  logic        awvalid [2];
  logic        awready [2];
  logic        wvalid [2];
  logic        wready [2];
  logic        bvalid [2];
  logic        bready [2];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t rq[$];
  exp_t bq[$];
  exp_t me;
  int   rrise [2];
  int   brise [2];
  logic rv_prev [2];
  logic bv_prev [2];

  logic [31:0] tbl [4];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  ysyx_24080014_axil_sram #(.RD_LAT(1), .WR_LAT(1), .RAND_LAT(1'b0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0])
  );

  ysyx_24080014_axil_sram #(.RD_LAT(1), .WR_LAT(1), .RAND_LAT(1'b1)) dut_rand (
    .aclk(aclk), .aresetn(aresetn),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
    .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_lat(input string name, input int lat, input int lmin, input int lmax);
    total++;
    if (lat < lmin || lat > lmax) begin
      bad++;
      $display("FAIL %s: latency %0d expected %0d..%0d (cycle %0d)", name, lat, lmin, lmax, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  task automatic rd(input int s, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] r, input int lmin, input int lmax);
    int n = 0;
    araddr[s]  = a;
    arvalid[s] = 1'b1;
    @(negedge aclk);
    while (!arready[s] && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!arready[s]) timeout("ar_handshake");
    else rq.push_back('{s, d, r, cyc + 1, lmin, lmax});
    @(posedge aclk);
    #1;
    arvalid[s] = 1'b0;
  endtask

  task automatic wr(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                    input int gap, input logic [1:0] r, input int lmin, input int lmax);
    int n = 0;
    awaddr[s]  = a;
    wdata[s]   = d;
    wstrb[s]   = st;
    awvalid[s] = 1'b1;
    if (gap < 0) wvalid[s] = 1'b1;
    @(negedge aclk);
    while (!(awready[s] && (gap >= 0 || wready[s])) && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 50) timeout("aw_handshake");
    if (gap >= 0) begin
      @(posedge aclk);
      #1;
      awvalid[s] = 1'b0;
      repeat (gap) begin
        @(negedge aclk);
        chk("aw_w_split_readys", {30'd0, awready[s], wready[s]}, 32'd1);
      end
      @(posedge aclk);
      #1;
      wvalid[s] = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!wready[s] && n < 50) begin
        @(negedge aclk);
        n++;
      end
      if (!wready[s]) timeout("w_handshake");
    end
    bq.push_back('{s, 32'h0, r, cyc + 1, lmin, lmax});
    @(posedge aclk);
    #1;
    awvalid[s] = 1'b0;
    wvalid[s]  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 100) begin
      timeout("drain");
      rq.delete();
      bq.delete();
    end
    @(posedge aclk);
    #1;
  endtask

  // Response monitor: pops the scoreboard whenever an R or B handshake is about to complete
  initial begin
    for (int s = 0; s < 2; s++) begin
      rv_prev[s] = 1'b0;
      bv_prev[s] = 1'b0;
      rrise[s]   = 0;
      brise[s]   = 0;
    end
    forever begin
      @(negedge aclk);
      for (int s = 0; s < 2; s++) begin
        if (rvalid[s] && !rv_prev[s]) rrise[s] = cyc;
        rv_prev[s] = rvalid[s];
        if (bvalid[s] && !bv_prev[s]) brise[s] = cyc;
        bv_prev[s] = bvalid[s];
        if (rvalid[s] && rready[s]) begin
          if (rq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL r_unexpected: inst %0d rvalid with nothing expected", s);
          end else begin
            me = rq.pop_front();
            chk("r_inst", s, me.s);
            chk("rdata", rdata[s], me.data);
            chk("rresp", {30'd0, rresp[s]}, {30'd0, me.resp});
            chk_lat("r_latency", rrise[s] - me.hs, me.lmin, me.lmax);
          end
        end
        if (bvalid[s] && bready[s]) begin
          if (bq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_unexpected: inst %0d bvalid with nothing expected", s);
          end else begin
            me = bq.pop_front();
            chk("b_inst", s, me.s);
            chk("bresp", {30'd0, bresp[s]}, {30'd0, me.resp});
            chk_lat("b_latency", brise[s] - me.hs, me.lmin, me.lmax);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int s = 0; s < 2; s++) begin
      araddr[s] = 32'h0; arvalid[s] = 1'b0; rready[s] = 1'b1;
      awaddr[s] = 32'h0; awvalid[s] = 1'b0; wdata[s] = 32'h0;
      wstrb[s] = 4'h0; wvalid[s] = 1'b0; bready[s] = 1'b1;
    end
    tbl[0] = 32'h0102_0304; tbl[1] = 32'hCAFE_F00D;
    tbl[2] = 32'h5A5A_A5A5; tbl[3] = 32'h0BAD_C0DE;

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_arready", {31'd0, arready[0]}, 32'd0);
    chk("rst_awready", {31'd0, awready[0]}, 32'd0);
    chk("rst_wready", {31'd0, wready[0]}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid[0]}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid[0]}, 32'd0);
    chk("rst_rdata", rdata[0], 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("idle_readys", {29'd0, arready[0], awready[0], wready[0]}, 32'd7);

    // 1: full write then read back
    wr(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, -1, 2'b00, 1, 1);
    drain();
    rd(0, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 1, 1);
    drain();

    // 2: single byte lane write
    wr(0, 32'h8000_0010, 32'h0000_5500, 4'b0010, -1, 2'b00, 1, 1);
    drain();
    rd(0, 32'h8000_0010, 32'hDEAD_55EF, 2'b00, 1, 1);
    drain();
    rd(0, 32'h8000_0013, 32'hDEAD_55EF, 2'b00, 1, 1);
    drain();

    // 3: rready backpressure, held arvalid accepted the cycle after the R handshake
    rready[0]  = 1'b0;
    araddr[0]  = 32'h8000_0010;
    arvalid[0] = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!arready[0] && n < 50) begin @(negedge aclk); n++; end
    if (!arready[0]) timeout("bp_ar");
    else rq.push_back('{0, 32'hDEAD_55EF, 2'b00, cyc + 1, 1, 1});
    n = 0;
    @(negedge aclk);
    while (!rvalid[0] && n < 20) begin @(negedge aclk); n++; end
    if (!rvalid[0]) timeout("bp_rvalid");
    repeat (5) begin
      @(negedge aclk);
      chk("bp_rvalid_hold", {31'd0, rvalid[0]}, 32'd1);
      chk("bp_rdata_hold", rdata[0], 32'hDEAD_55EF);
      chk("bp_arready_low", {31'd0, arready[0]}, 32'd0);
    end
    @(posedge aclk);
    #1;
    rready[0] = 1'b1;
    @(negedge aclk);
    chk("ar_not_early", {31'd0, arready[0]}, 32'd0);
    @(negedge aclk);
    chk("ar_after_r", {31'd0, arready[0]}, 32'd1);
    rq.push_back('{0, 32'hDEAD_55EF, 2'b00, cyc + 1, 1, 1});
    @(posedge aclk);
    #1;
    arvalid[0] = 1'b0;
    drain();

    // 4: out-of-range read and write, memory untouched; last word in range
    rd(0, 32'h0000_0000, 32'h0, 2'b10, 1, 1);
    drain();
    wr(0, 32'h9000_0000, 32'hFFFF_FFFF, 4'hF, -1, 2'b10, 1, 1);
    drain();
    rd(0, 32'h8000_0010, 32'hDEAD_55EF, 2'b00, 1, 1);
    drain();
    wr(0, 32'h8000_0FFC, 32'hA5A5_0001, 4'hF, -1, 2'b00, 1, 1);
    drain();
    rd(0, 32'h8000_0FFC, 32'hA5A5_0001, 2'b00, 1, 1);
    drain();
    rd(0, 32'h8000_1000, 32'h0, 2'b10, 1, 1);
    drain();

    // 5: AW three cycles ahead of W
    wr(0, 32'h8000_0020, 32'h1234_5678, 4'hF, 3, 2'b00, 1, 1);
    drain();
    rd(0, 32'h8000_0020, 32'h1234_5678, 2'b00, 1, 1);
    drain();

    // 6: asynchronous reset during a pending response
    rready[0] = 1'b0;
    rd(0, 32'h8000_0010, 32'hDEAD_55EF, 2'b00, 1, 1);
    n = 0;
    @(negedge aclk);
    while (!rvalid[0] && n < 20) begin @(negedge aclk); n++; end
    if (!rvalid[0]) timeout("rst_pending_rvalid");
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_rvalid", {31'd0, rvalid[0]}, 32'd0);
    chk("async_arready", {31'd0, arready[0]}, 32'd0);
    chk("async_rdata", rdata[0], 32'h0);
    rq.delete();
    @(negedge aclk);
    aresetn   = 1'b1;
    rready[0] = 1'b1;
    @(posedge aclk);
    #1;
    chk("post_rst_arready", {31'd0, arready[0]}, 32'd1);
    rd(0, 32'h8000_0010, 32'hDEAD_55EF, 2'b00, 1, 1);
    drain();

    // 6: random latency instance
    for (int k = 0; k < 4; k++) begin
      wr(1, 32'h8000_0000 + 32'(4 * k), tbl[k], 4'hF, -1, 2'b00, 1, 4);
      drain();
    end
    for (int i = 0; i < 20; i++) begin
      rd(1, 32'h8000_0000 + 32'(4 * (i % 4)), tbl[i % 4], 2'b00, 1, 4);
      drain();
    end

    chk("scoreboard_empty", rq.size() + bq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
